ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 46 ++++
 rtl/ps2_sync.sv | 42 ++++
 rtl/ps2_host_tx.sv | 225 ++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encoding, frame length, default timing
// constants and frame-level helper functions. Used by the host transmitter
// and the PS/2 receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INHIBIT = 3'd1,
        ST_REQUEST = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_ACK     = 3'd4,
        ST_RECOVER = 3'd5
    } ps2_state_e;

    // Start + 8 data + parity + stop bits on the wire
    localparam int PS2_FRAME_BITS = 11;

    // Defaults assume a 20 MHz system clock
    localparam int PS2_DEF_INHIBIT_CYCLES = 2000;    // 100 us
    localparam int PS2_DEF_TIMEOUT_CYCLES = 400000;  // 20 ms

    // PS/2 uses odd parity: the parity bit makes the total count of ones odd
    function automatic logic odd_parity(input logic [7:0] data);
        return ~(^data);
    endfunction

    // Line level the host presents after device falling edge edge_num
    // (1..8 data LSB first, 9 parity, anything else released/high)
    function automatic logic frame_level(input logic [7:0] data, input logic [3:0] edge_num);
        logic level;
        case (edge_num)
            4'd1:    level = data[0];
            4'd2:    level = data[1];
            4'd3:    level = data[2];
            4'd4:    level = data[3];
            4'd5:    level = data[4];
            4'd6:    level = data[5];
            4'd7:    level = data[6];
            4'd8:    level = data[7];
            4'd9:    level = odd_parity(data);
            default: level = 1'b1;
        endcase
        return level;
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizers for the raw PS/2 clock and data lines plus a
// falling-edge detector on the synchronized clock. Lines idle high, so the
// flops reset to 1 to avoid a false edge when reset is released.
module ps2_sync (
    input  logic clk,
    input  logic reset,
    input  logic ps2clk,
    input  logic ps2dat,
    output logic clk_sync,
    output logic dat_sync,
    output logic clk_fall
);

    logic clk_meta_r;
    logic clk_sync_r;
    logic clk_prev_r;
    logic dat_meta_r;
    logic dat_sync_r;

    // Synchronizer chains and the one-cycle delayed clock used for edge detect
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_meta_r <= 1'b1;
            clk_sync_r <= 1'b1;
            clk_prev_r <= 1'b1;
            dat_meta_r <= 1'b1;
            dat_sync_r <= 1'b1;
        end else begin
            clk_meta_r <= ps2clk;
            clk_sync_r <= clk_meta_r;
            clk_prev_r <= clk_sync_r;
            dat_meta_r <= ps2dat;
            dat_sync_r <= dat_meta_r;
        end
    end

    assign clk_sync = clk_sync_r;
    assign dat_sync = dat_sync_r;
    // Synchronized clock was 1 last cycle and is 0 now
    assign clk_fall = clk_prev_r & ~clk_sync_r;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Inhibits the bus, issues a request to
// send, shifts out one byte (LSB first, odd parity, stop) on device clock
// falling edges and checks the device acknowledge.
// Optional build macro PS2_TX_TIMEOUT_EN adds a watchdog that aborts the
// frame when the device stops clocking for TIMEOUT_CYCLES cycles.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = PS2_DEF_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = PS2_DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2clk,
    input  logic       ps2dat,
    output logic       ps2clk_oe,
    output logic       ps2dat_oe
);

    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [3:0] LAST_SHIFT_EDGE = 4'(PS2_FRAME_BITS - 2);

    ps2_state_e       state_r, state_s;
    logic [INH_W-1:0] inh_cnt_r, inh_cnt_s;
    logic [3:0]       edge_cnt_r, edge_cnt_s;
    logic [7:0]       data_r, data_s;
    logic             tx_ready_r, tx_ready_s;
    logic             tx_done_r, done_s;
    logic             tx_err_r, err_s;
    logic             clk_oe_r, clk_oe_s;
    logic             dat_oe_r, dat_oe_s;
    logic             clk_sync_s, dat_sync_s, clk_fall_s;
    logic             timeout_s;

    ps2_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .ps2clk   (ps2clk),
        .ps2dat   (ps2dat),
        .clk_sync (clk_sync_s),
        .dat_sync (dat_sync_s),
        .clk_fall (clk_fall_s)
    );

`ifdef PS2_TX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_r, to_cnt_s;
    logic            frame_active_s;

    // Watchdog: cycles since the last device falling edge while the device owns the clock
    always_comb begin
        frame_active_s = (state_r == ST_REQUEST) || (state_r == ST_SHIFT) || (state_r == ST_ACK);
        to_cnt_s       = '0;
        if (frame_active_s && !clk_fall_s) begin
            to_cnt_s = to_cnt_r + 1'b1;
        end else begin
            to_cnt_s = '0;
        end
        timeout_s = frame_active_s && !clk_fall_s && (to_cnt_r == TO_LAST);
    end

    // Watchdog counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_r <= '0;
        end else begin
            to_cnt_r <= to_cnt_s;
        end
    end
`else
    // Watchdog compiled out: wait for device edges forever (parameter is always positive)
    assign timeout_s = (TIMEOUT_CYCLES < 0);
`endif

    // Next-state logic and decode of the registered bus/handshake outputs
    always_comb begin
        state_s    = state_r;
        inh_cnt_s  = inh_cnt_r;
        edge_cnt_s = edge_cnt_r;
        data_s     = data_r;
        done_s     = 1'b0;
        err_s      = 1'b0;
        clk_oe_s   = 1'b0;
        dat_oe_s   = 1'b0;
        tx_ready_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (tx_valid && tx_ready_r) begin
                    state_s    = ST_INHIBIT;
                    data_s     = tx_data;
                    inh_cnt_s  = '0;
                    edge_cnt_s = 4'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_INHIBIT: begin
                if (inh_cnt_r == INH_LAST) begin
                    state_s    = ST_REQUEST;
                    inh_cnt_s  = '0;
                    edge_cnt_s = 4'd0;
                end else begin
                    inh_cnt_s = inh_cnt_r + 1'b1;
                end
            end
            ST_REQUEST: begin
                // First device edge clocks the start bit; bit 0 goes out now
                if (clk_fall_s) begin
                    state_s    = ST_SHIFT;
                    edge_cnt_s = 4'd1;
                end else begin
                    state_s = ST_REQUEST;
                end
            end
            ST_SHIFT: begin
                if (clk_fall_s) begin
                    edge_cnt_s = edge_cnt_r + 4'd1;
                    if (edge_cnt_r == LAST_SHIFT_EDGE) begin
                        state_s = ST_ACK;
                    end else begin
                        state_s = ST_SHIFT;
                    end
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_ACK: begin
                // Device pulls data low around the final edge to acknowledge
                if (clk_fall_s) begin
                    edge_cnt_s = edge_cnt_r + 4'd1;
                    state_s    = ST_RECOVER;
                    if (dat_sync_s) begin
                        err_s = 1'b1;
                    end else begin
                        done_s = 1'b1;
                    end
                end else begin
                    state_s = ST_ACK;
                end
            end
            ST_RECOVER: begin
                if (clk_sync_s && dat_sync_s) begin
                    state_s    = ST_IDLE;
                    edge_cnt_s = 4'd0;
                end else begin
                    state_s = ST_RECOVER;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                edge_cnt_s = 4'd0;
            end
        endcase

        if (timeout_s) begin
            state_s = ST_RECOVER;
            err_s   = 1'b1;
            done_s  = 1'b0;
        end else begin
            state_s = state_s;
        end

        // Outputs follow the state being entered so they are registered alongside it
        case (state_s)
            ST_IDLE: begin
                tx_ready_s = 1'b1;
            end
            ST_INHIBIT: begin
                clk_oe_s = 1'b1;
                dat_oe_s = (inh_cnt_s == INH_LAST);
            end
            ST_REQUEST: begin
                dat_oe_s = 1'b1;
            end
            ST_SHIFT: begin
                dat_oe_s = ~frame_level(data_s, edge_cnt_s);
            end
            default: begin
                clk_oe_s = 1'b0;
                dat_oe_s = 1'b0;
            end
        endcase
    end

    // State, counters, latched byte and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            inh_cnt_r  <= '0;
            edge_cnt_r <= 4'd0;
            data_r     <= 8'd0;
            tx_ready_r <= 1'b0;
            tx_done_r  <= 1'b0;
            tx_err_r   <= 1'b0;
            clk_oe_r   <= 1'b0;
            dat_oe_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            inh_cnt_r  <= inh_cnt_s;
            edge_cnt_r <= edge_cnt_s;
            data_r     <= data_s;
            tx_ready_r <= tx_ready_s;
            tx_done_r  <= done_s;
            tx_err_r   <= err_s;
            clk_oe_r   <= clk_oe_s;
            dat_oe_r   <= dat_oe_s;
        end
    end

    assign tx_ready  = tx_ready_r;
    assign tx_done   = tx_done_r;
    assign tx_err    = tx_err_r;
    assign ps2clk_oe = clk_oe_r;
    assign ps2dat_oe = dat_oe_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a behavioural PS/2 device clocks frames,
// captures the bits on the open-drain lines and acks or refuses them.
// Define PS2_TX_TIMEOUT_EN for both bench and RTL to exercise the watchdog.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TO   = 300;
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx_done, tx_err;
    logic       ps2clk_oe, ps2dat_oe;
    logic       dev_clk, dev_dat;
    logic       ps2clk, ps2dat;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;

    // Open-drain wired-AND of host and device
    assign ps2clk = dev_clk & ~ps2clk_oe;
    assign ps2dat = dev_dat & ~ps2dat_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_done   (tx_done),
        .tx_err    (tx_err),
        .ps2clk    (ps2clk),
        .ps2dat    (ps2dat),
        .ps2clk_oe (ps2clk_oe),
        .ps2dat_oe (ps2dat_oe)
    );

    always #5 clk = ~clk;

    // Count pulse cycles (a stretched pulse counts more than once)
    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (tx_err) err_cnt++;
        if (tx_done && tx_err) both_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("reset_clk_oe", ps2clk_oe, 1'b0);
        check_eq("reset_dat_oe", ps2dat_oe, 1'b0);
        check_eq("reset_pulses", {tx_done, tx_err}, 2'b00);
        reset = 1'b0;
        @(negedge clk);
        check_eq("ready_after_reset", tx_ready, 1'b1);
    endtask

    task automatic start_req(input logic [7:0] b, input logic hold_valid);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        if (hold_valid) tx_data = ~b;
        else tx_valid = 1'b0;
    endtask

    task automatic measure_inhibit(output int len, output int dat_len, output logic last_dat);
        len = 0; dat_len = 0; last_dat = 1'b0;
        for (int i = 0; i < INH + 20; i++) begin
            if (ps2clk_oe) begin
                len++;
                last_dat = ps2dat_oe;
                if (ps2dat_oe) dat_len++;
            end else if (len > 0) begin
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic dev_edge(output logic smp);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        smp = ps2dat;
        dev_clk = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 60; i++) begin
            if (tx_ready) break;
            @(negedge clk);
        end
        check_eq("ready_back", tx_ready, 1'b1);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic exp_par, input logic do_ack, input logic hold_valid);
        int d0, e0, inh_len, inh_dat;
        logic last_dat, smp;
        logic [9:0] bits;
        d0 = done_cnt; e0 = err_cnt;
        start_req(b, hold_valid);
        measure_inhibit(inh_len, inh_dat, last_dat);
        check_eq("inhibit_len", inh_len, INH);
        check_eq("inhibit_dat_cycles", inh_dat, 1);
        check_eq("inhibit_dat_last", last_dat, 1'b1);
        check_eq("start_bit", ps2dat, 1'b0);
        repeat (HALF) @(negedge clk);
        for (int e = 0; e < 10; e++) begin
            dev_edge(smp);
            bits[e] = smp;
            if (hold_valid) tx_data = tx_data + 8'h37;
        end
        tx_valid = 1'b0;
        dev_dat = ~do_ack;
        repeat (2) @(negedge clk);
        dev_edge(smp);
        dev_dat = 1'b1;
        wait_ready();
        @(posedge clk);
        check_eq("data_byte", bits[7:0], b);
        check_eq("parity_bit", bits[8], exp_par);
        check_eq("stop_bit", bits[9], 1'b1);
        check_eq("done_pulses", done_cnt - d0, do_ack ? 1 : 0);
        check_eq("err_pulses", err_cnt - e0, do_ack ? 0 : 1);
    endtask

    task automatic stall_after_edge5();
        int d0, e0, inh_len, inh_dat, k;
        logic last_dat, smp;
        d0 = done_cnt; e0 = err_cnt; k = 0;
        start_req(8'hA5, 1'b0);
        measure_inhibit(inh_len, inh_dat, last_dat);
        repeat (HALF) @(negedge clk);
        for (int e = 0; e < 4; e++) dev_edge(smp);
        dev_clk = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
        // Edge 5 is registered 3 clk edges after the line drops (2 sync + detect)
        for (int i = 1; i <= TO + 40; i++) begin
            @(negedge clk);
            if (i == HALF) dev_clk = 1'b1;
            if (tx_err) begin
                k = i;
                check_eq("timeout_clk_oe", ps2clk_oe, 1'b0);
                check_eq("timeout_dat_oe", ps2dat_oe, 1'b0);
                break;
            end
        end
        dev_clk = 1'b1;
        check_eq("timeout_latency", k, TO + 3);
        wait_ready();
        @(posedge clk);
        check_eq("timeout_err_pulses", err_cnt - e0, 1);
        check_eq("timeout_done_pulses", done_cnt - d0, 0);
`else
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b1;
        repeat (3 * TO) @(negedge clk);
        @(posedge clk);
        check_eq("stall_no_err", err_cnt - e0, 0);
        check_eq("stall_busy", tx_ready, 1'b0);
        do_reset();
        @(posedge clk);
        check_eq("stall_reset_pulses", (err_cnt - e0) + (done_cnt - d0), 0);
`endif
    endtask

    // Bound total run time
    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int d0, e0;
        logic smp;
        reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        dev_clk = 1'b1; dev_dat = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("por_clk_oe", ps2clk_oe, 1'b0);
        check_eq("por_dat_oe", ps2dat_oe, 1'b0);
        check_eq("por_pulses", {tx_done, tx_err}, 2'b00);
        reset = 1'b0;
        @(negedge clk);
        check_eq("por_ready", tx_ready, 1'b1);

        // 0xED: six ones -> parity 1
        send_frame(8'hED, 1'b1, 1'b1, 1'b0);
        // 0x01: one one -> parity 0; 0x00 -> parity 1
        send_frame(8'h01, 1'b0, 1'b1, 1'b0);
        send_frame(8'h00, 1'b1, 1'b1, 1'b0);
        // 0xFF refused by device: eight ones -> parity 1
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        // tx_valid held with changing data: 0x5A has four ones -> parity 1
        send_frame(8'h5A, 1'b1, 1'b1, 1'b1);

        // Reset while inhibiting
        d0 = done_cnt; e0 = err_cnt;
        start_req(8'h3C, 1'b0);
        repeat (4) @(negedge clk);
        check_eq("inhibit_active", ps2clk_oe, 1'b1);
        do_reset();
        @(posedge clk);
        check_eq("inhibit_reset_pulses", (done_cnt - d0) + (err_cnt - e0), 0);

        // Reset at shift edge 4
        d0 = done_cnt; e0 = err_cnt;
        start_req(8'h00, 1'b0);
        repeat (INH + 2) @(negedge clk);
        repeat (HALF) @(negedge clk);
        for (int e = 0; e < 3; e++) dev_edge(smp);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        check_eq("shift4_dat_oe", ps2dat_oe, 1'b1);
        dev_clk = 1'b1;
        do_reset();
        @(posedge clk);
        check_eq("shift_reset_pulses", (done_cnt - d0) + (err_cnt - e0), 0);

        stall_after_edge5();

        check_eq("done_err_overlap", both_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
